wb_uart_slave: RTL and testbench
================================

WB_UART_SLAVE -- requirements
Module: wb_uart_slave

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 16 (power of 2, 2..128): entries in each of the TX and RX FIFOs.
REQ-002 The module SHALL have one clock; reset is asynchronous and active-high. Ports: i_clk in 1, system clock; i_reset in 1, async active-high reset.
REQ-003 Port i_wb_cyc in 1: bus cycle active.
REQ-004 Port i_wb_stb in 1: request strobe.
REQ-005 Port i_wb_we in 1: 1 = write, 0 = read.
REQ-006 Port i_wb_addr in 30: word address; only bits [1:0] are decoded and upper bits are ignored (aliased).
REQ-007 Port i_wb_data in 32: write data.
REQ-008 Port i_wb_sel in 4: byte enables.
REQ-009 Port o_wb_stall out 1: tied 0.
REQ-010 Port o_wb_ack out 1: access complete.
REQ-011 Port o_wb_err out 1: access error.
REQ-012 Port o_wb_data out 32: read data.
REQ-013 Port o_tx_data out 8: byte to the UART transmitter.
REQ-014 Port o_tx_valid out 1: single-cycle transmit-start pulse.
REQ-015 Port i_tx_busy in 1: transmitter busy.
REQ-016 Port i_rx_data in 8: received byte.
REQ-017 Port i_rx_stb in 1: single-cycle received-byte strobe.

Function
REQ-018 A request SHALL be accepted on any cycle with i_wb_cyc&i_wb_stb; o_wb_ack or o_wb_err SHALL pulse exactly 1 cycle later, and only if i_wb_cyc is still 1 then. The side effect of the request SHALL occur regardless.
REQ-019 Register map (addr[1:0]):
- 0 TXDATA: a write with sel[0] pushes data[7:0] to the TX FIFO; a read returns 0.
- 1 RXDATA: a read pops the RX FIFO and returns {23'b0, valid, byte}; when the FIFO is empty it returns 0 and does not pop. A write is acked with no effect.
- 2 STATUS: a read returns [7:0] tx_count, [15:8] rx_count, [16] tx_full, [17] rx_empty, [18] tx_ovf, [19] rx_ovf, [20] tx_active, other bits 0. A write with sel[2] clears bit 18/19 where the data bit is 1 (W1C).
- 3: o_wb_err instead of ack, no side effect, o_wb_data = 0.
REQ-020 o_wb_data SHALL be valid in the ack cycle and 0 otherwise.
REQ-021 A TXDATA write while the TX FIFO is full SHALL be acked, the byte dropped, and tx_ovf set (sticky).
REQ-022 An i_rx_stb while the RX FIFO is full SHALL drop the byte and set rx_ovf (sticky). A push and a pop in the same cycle SHALL both take effect with the count unchanged, including when the FIFO is full.
REQ-023 A W1C clear and a new overflow event in the same cycle: the flag SHALL end set.
REQ-024 The TX FSM SHALL have four states:
- IDLE -> START when the TX FIFO is non-empty and i_tx_busy=0.
- START: o_tx_valid=1 for one cycle, o_tx_data = FIFO head, head popped; -> GUARD.
- GUARD: one cycle, busy ignored; -> WAIT.
- WAIT -> IDLE when i_tx_busy=0.
REQ-025 tx_active SHALL be 1 in any TX state other than IDLE.
REQ-026 o_tx_data SHALL hold the last sent byte between pulses.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH. Counts SHALL range 0..FIFO_DEPTH and be zero-extended into their 8-bit STATUS fields.
REQ-028 A TX push and a TX pop in the same cycle SHALL leave tx_count unchanged.

Reset
REQ-029 While i_reset=1 the module SHALL hold all outputs at 0, both FIFOs empty, both overflow flags 0, and the TX FSM in IDLE; the effect SHALL be immediate (asynchronous).
REQ-030 Reset mid-transmission SHALL drop o_tx_valid immediately and discard FIFO contents. The first cycle after release SHALL behave as idle.

Verification
REQ-031 Single send: write 0x41 to addr 0 -> ack next cycle; o_tx_valid pulses with o_tx_data=0x41 within 2 cycles of the write.
REQ-032 Back-to-back send: write 0x10, 0x11, 0x12 with i_tx_busy modelled high for 10 cycles after each pulse -> exactly 3 pulses, in order, each no earlier than busy falling; STATUS tx_count reaches 0.
REQ-033 TX overflow: hold i_tx_busy=1 and write FIFO_DEPTH+1 bytes -> tx_full=1, tx_count=16, tx_ovf=1; a STATUS write of 0x00040000 clears tx_ovf.
REQ-034 RX path: strobe 0x55 then 0xAA; read addr 1 twice -> 0x155 then 0x1AA; a third read returns 0x000 and rx_empty=1.
REQ-035 RX boundary: fill the RX FIFO, then assert i_rx_stb in the same cycle a RXDATA read is accepted -> rx_count stays 16 and rx_ovf stays 0. One further strobe with no read -> rx_ovf=1.
REQ-036 Error/abort cases: a read of addr 3 -> o_wb_err=1 with o_wb_ack=0. i_wb_cyc dropped the cycle after a TXDATA write -> no ack, but the byte is still queued. i_reset pulsed during WAIT -> all outputs 0 and tx_count=0.

Source files
------------

// File: rtl/wb_uart_slave.sv
// wb_uart_slave
//   Wishbone register front-end for a byte UART. A TX FIFO feeds an external
//   transmitter through a small handshake FSM. An RX FIFO collects bytes
//   strobed in by an external receiver.
//
// Ports
//   i_clk, i_reset         : system clock, asynchronous active-high reset
//   i_wb_cyc/stb/we        : Wishbone request qualifiers
//   i_wb_addr[29:0]        : word address, only [1:0] decoded
//   i_wb_data[31:0]        : write data
//   i_wb_sel[3:0]          : byte enables
//   o_wb_stall             : always 0
//   o_wb_ack / o_wb_err    : one-cycle response, gated by i_wb_cyc
//   o_wb_data[31:0]        : read data, non-zero only during ack
//   o_tx_data[7:0]         : byte to transmitter, held between pulses
//   o_tx_valid             : one-cycle transmit-start pulse
//   i_tx_busy              : transmitter busy
//   i_rx_data[7:0], i_rx_stb : received byte and its strobe
//
// Register map (addr[1:0])
//   0 TXDATA  write pushes data[7:0] if sel[0]; reads 0
//   1 RXDATA  read pops: {23'b0, valid, byte}; write ignored
//   2 STATUS  [7:0] tx_count [15:8] rx_count [16] tx_full [17] rx_empty
//             [18] tx_ovf [19] rx_ovf [20] tx_active; W1C on 18/19 with sel[2]
//   3         error response
module wb_uart_slave #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [29:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic [31:0] o_wb_data,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_busy,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_stb
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_GUARD, S_WAIT} tx_state_t;

    // ---------------- request decode ----------------
    logic       req;
    logic [1:0] a;
    logic       wr_tx, rd_rx, wr_st, bad_addr;

    assign req      = i_wb_cyc & i_wb_stb;
    assign a        = i_wb_addr[1:0];
    assign wr_tx    = req &  i_wb_we & (a == 2'd0) & i_wb_sel[0];
    assign rd_rx    = req & ~i_wb_we & (a == 2'd1);
    assign wr_st    = req &  i_wb_we & (a == 2'd2) & i_wb_sel[2];
    assign bad_addr = req & (a == 2'd3);

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_wp, tx_rp;
    logic [CW-1:0] tx_count;
    logic          tx_full, tx_empty, tx_push, tx_pop, tx_drop;
    tx_state_t     state, state_nx;

    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    assign tx_pop   = (state == S_START);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign tx_push  = wr_tx & (~tx_full | tx_pop);
    assign tx_drop  = wr_tx & ~tx_push;

    always_ff @(posedge i_clk)
        if (tx_push) tx_mem[tx_wp] <= i_wb_data[7:0];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_wp    <= '0;
            tx_rp    <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + AW'(1);
            if (tx_pop)  tx_rp <= tx_rp + AW'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] rx_wp, rx_rp;
    logic [CW-1:0] rx_count;
    logic          rx_full, rx_empty, rx_push, rx_pop, rx_drop;

    assign rx_full  = (rx_count == FULL_CNT);
    assign rx_empty = (rx_count == '0);
    assign rx_pop   = rd_rx & ~rx_empty;
    assign rx_push  = i_rx_stb & (~rx_full | rx_pop);
    assign rx_drop  = i_rx_stb & ~rx_push;

    always_ff @(posedge i_clk)
        if (rx_push) rx_mem[rx_wp] <= i_rx_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rx_wp    <= '0;
            rx_rp    <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + AW'(1);
            if (rx_pop)  rx_rp <= rx_rp + AW'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end

    // ---------------- sticky overflow flags ----------------
    // A new drop wins over a simultaneous W1C clear.
    logic tx_ovf, rx_ovf;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            tx_ovf <= (tx_ovf & ~(wr_st & i_wb_data[18])) | tx_drop;
            rx_ovf <= (rx_ovf & ~(wr_st & i_wb_data[19])) | rx_drop;
        end
    end

    // ---------------- TX FSM ----------------
    logic       tx_active;
    logic [7:0] tx_data_q;

    assign tx_active = (state != S_IDLE);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!tx_empty && !i_tx_busy) state_nx = S_START;
            S_START: state_nx = S_GUARD;
            // The transmitter may not have raised busy yet; skip one cycle.
            S_GUARD: state_nx = S_WAIT;
            S_WAIT:  if (!i_tx_busy) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Load the head on entry to START so the byte is on o_tx_data with the
    // pulse, and hold it afterwards.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            tx_data_q <= '0;
        else if (state == S_IDLE && state_nx == S_START)
            tx_data_q <= tx_mem[tx_rp];
    end

    assign o_tx_valid = (state == S_START);
    assign o_tx_data  = tx_data_q;

    // ---------------- read mux / response ----------------
    logic [31:0] rdata, rdata_q;
    logic        ack_q, err_q;

    always_comb begin
        rdata = '0;
        case (a)
            2'd1:    if (!rx_empty) rdata = {23'b0, 1'b1, rx_mem[rx_rp]};
            2'd2:    rdata = {11'b0, tx_active, rx_ovf, tx_ovf, rx_empty, tx_full,
                              8'(rx_count), 8'(tx_count)};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= req & ~bad_addr;
            err_q   <= bad_addr;
            rdata_q <= (req & ~i_wb_we) ? rdata : '0;
        end
    end

    // An abandoned cycle gets no response; the side effect has already happened.
    assign o_wb_ack   = ack_q & i_wb_cyc;
    assign o_wb_err   = err_q & i_wb_cyc;
    assign o_wb_data  = o_wb_ack ? rdata_q : '0;
    assign o_wb_stall = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{i_wb_addr[29:2], i_wb_data[31:20], i_wb_data[17:8],
                           i_wb_sel[3], i_wb_sel[1]};
endmodule

// File: tb/tb_wb_uart_slave.sv
module tb_wb_uart_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  sel = '0;
    logic        stall, ack, err, tx_valid;
    logic [31:0] rdat;
    logic [7:0]  tx_data;
    logic        busy_hold = 1'b0, busy_model = 1'b0, tx_busy;
    logic [7:0]  rx_data = '0;
    logic        rx_stb = 1'b0;

    assign tx_busy = busy_hold | busy_model;

    wb_uart_slave #(.FIFO_DEPTH(16)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_addr(addr),
        .i_wb_data(wdat), .i_wb_sel(sel),
        .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_err(err), .o_wb_data(rdat),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_busy(tx_busy),
        .i_rx_data(rx_data), .i_rx_stb(rx_stb)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // bus response scoreboard
    typedef struct { logic [31:0] data; logic err; } rsp_t;
    rsp_t sb[$];
    // expected transmit bytes, in order
    logic [7:0] tx_exp[$];

    // transmit monitor + transmitter busy model (busy 10 cycles after each pulse)
    int cyc_n = 0, pulses = 0, last_pulse = 0, busy_cnt = 0;
    initial begin
        logic b;
        forever begin
            @(posedge clk);
            b = tx_busy;
            #2;
            cyc_n++;
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) busy_model = 1'b0;
            end
            if (tx_valid === 1'b1) begin
                pulses++;
                last_pulse = cyc_n;
                chk("tx_busy_at_start", b, 0);
                if (tx_exp.size() == 0) chk("tx_unexpected_pulse", 32'(tx_exp.size()), 1);
                else chk("tx_data", tx_data, tx_exp.pop_front());
                busy_model = 1'b1;
                busy_cnt = 10;
            end
        end
    end

    task automatic bus(input string tag, input logic w, input logic [29:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_d, input logic exp_e);
        rsp_t r;
        sb.push_back('{exp_d, exp_e});
        @(negedge clk);
        cyc = 1; stb = 1; we = w; addr = a; wdat = d; sel = s;
        @(negedge clk);
        stb = 0;
        r = sb.pop_front();
        chk({tag, "_ack"}, ack, !r.err);
        chk({tag, "_err"}, err, r.err);
        chk({tag, "_data"}, rdat, r.data);
        cyc = 0;
        #1;
        chk({tag, "_idle"}, {ack, err, rdat}, 0);
    endtask

    task automatic status(input string tag, input logic [31:0] exp);
        bus(tag, 1'b0, 30'd2, 32'd0, 4'hf, exp, 1'b0);
    endtask

    task automatic rx_push(input logic [7:0] b);
        @(negedge clk);
        rx_data = b; rx_stb = 1;
        @(negedge clk);
        rx_stb = 0;
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_ctl"}, {stall, ack, err, tx_valid, tx_data}, 0);
        chk({tag, "_data"}, rdat, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    initial begin
        int p0, acc;
        rsp_t r;
        // ---- reset state
        #12;
        chk_outs_zero("reset");
        @(negedge clk);
        rst = 0;
        status("st_idle", 32'h0002_0000);

        // ---- single send
        p0 = pulses;
        tx_exp.push_back(8'h41);
        bus("tx41", 1'b1, 30'd0, 32'h41, 4'h1, 32'd0, 1'b0);
        acc = cyc_n;
        repeat (3) @(negedge clk);
        chk("tx41_pulses", pulses - p0, 1);
        chk("tx41_latency_ok", 32'(last_pulse - acc <= 2), 1);
        repeat (20) @(negedge clk);
        chk("tx41_hold", tx_data, 8'h41);

        // ---- back-to-back send, bytes queued while busy then released
        busy_hold = 1;
        p0 = pulses;
        for (int i = 0; i < 3; i++) begin
            tx_exp.push_back(8'h10 + 8'(i));
            bus("tx_b2b", 1'b1, 30'd0, 32'h10 + i, 4'h1, 32'd0, 1'b0);
        end
        busy_hold = 0;
        repeat (80) @(negedge clk);
        chk("b2b_pulses", pulses - p0, 3);
        chk("b2b_exp_left", 32'(tx_exp.size()), 0);
        status("st_b2b", 32'h0002_0000);

        // ---- TX overflow with transmitter busy
        busy_hold = 1;
        for (int i = 0; i < 17; i++)
            bus("tx_fill", 1'b1, 30'd0, 32'hA0 + i, 4'h1, 32'd0, 1'b0);
        status("st_txovf", 32'h0007_0010);
        bus("w1c_tx", 1'b1, 30'd2, 32'h0004_0000, 4'b0100, 32'd0, 1'b0);
        status("st_txovf_clr", 32'h0003_0010);

        // ---- reset clears FIFO
        @(negedge clk);
        rst = 1;
        #1;
        chk_outs_zero("rst_full");
        @(negedge clk);
        rst = 0;
        status("st_after_rst", 32'h0002_0000);

        // ---- abort: cyc dropped the cycle after a TXDATA write
        @(negedge clk);
        cyc = 1; stb = 1; we = 1; addr = 30'd0; wdat = 32'h77; sel = 4'h1;
        @(negedge clk);
        cyc = 0; stb = 0;
        #1;
        chk("abort_ack", {ack, err}, 0);
        tx_exp.push_back(8'h77);
        status("st_abort", 32'h0002_0001);
        bus("tx78", 1'b1, 30'd0, 32'h78, 4'h1, 32'd0, 1'b0);
        p0 = pulses;
        busy_hold = 0;
        for (int i = 0; i < 20 && pulses == p0; i++) @(negedge clk);
        chk("abort_pulse", pulses - p0, 1);
        repeat (5) @(negedge clk);   // GUARD passed, now waiting on busy
        rst = 1;
        #1;
        chk_outs_zero("rst_wait");
        tx_exp.delete();
        @(negedge clk);
        rst = 0;
        busy_hold = 1;
        status("st_rst_wait", 32'h0002_0000);

        // ---- RX path
        rx_push(8'h55);
        rx_push(8'hAA);
        bus("rx0", 1'b0, 30'd1, 32'd0, 4'hf, 32'h155, 1'b0);
        bus("rx1", 1'b0, 30'd1, 32'd0, 4'hf, 32'h1AA, 1'b0);
        bus("rx_empty", 1'b0, 30'd1, 32'd0, 4'hf, 32'h000, 1'b0);
        status("st_rx_empty", 32'h0002_0000);

        // ---- RX boundary: full FIFO, push + pop in the same cycle
        for (int i = 0; i < 16; i++) rx_push(8'h20 + 8'(i));
        status("st_rx_full", 32'h0000_1000);
        sb.push_back('{32'h120, 1'b0});
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; addr = 30'd1; sel = 4'hf;
        rx_data = 8'hEE; rx_stb = 1;
        @(negedge clk);
        stb = 0; rx_stb = 0;
        r = sb.pop_front();
        chk("rx_same_ack", ack, !r.err);
        chk("rx_same_data", rdat, r.data);
        cyc = 0;
        status("st_rx_same", 32'h0000_1000);
        rx_push(8'hEF);
        status("st_rxovf", 32'h0008_1000);
        bus("rx_next", 1'b0, 30'd1, 32'd0, 4'hf, 32'h121, 1'b0);
        status("st_rx15", 32'h0008_0F00);
        bus("w1c_rx", 1'b1, 30'd2, 32'h0008_0000, 4'b0100, 32'd0, 1'b0);
        status("st_rx_clr", 32'h0000_0F00);

        // ---- error / alias / ignored writes
        bus("err_rd", 1'b0, 30'd3, 32'd0, 4'hf, 32'd0, 1'b1);
        bus("err_wr", 1'b1, 30'h3FFF_FFFF, 32'h41, 4'hf, 32'd0, 1'b1);
        bus("rx_wr", 1'b1, 30'd1, 32'hFF, 4'hf, 32'd0, 1'b0);
        bus("alias_st", 1'b0, 30'h3FFF_FFF6, 32'd0, 4'hf, 32'h0000_0F00, 1'b0);
        bus("txd_rd", 1'b0, 30'd0, 32'd0, 4'hf, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
